pipe_ctrl: RTL

Pipeline control unit for the five-stage core. Each cycle it decides which pipeline registers advance and which receive a bubble: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves five conditions in a fixed priority order: data-memory wait states, branch/jump redirects resolved in MEM, multi-cycle multiply/divide occupancy, load-use hazards and instruction-memory wait states. Its write-enable outputs drive the `wren` pins of the stage registers. Its flush outputs are ANDed (inverted) into each stage register's synchronous clear.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_hazard_detect.sv | 17 +
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline control unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MULDIV     = 2'd1,
    ST_KILL_FETCH = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Stage advance enables, PC first, in pipeline order.
  typedef struct packed {
    logic pc;
    logic fd;
    logic de;
    logic em;
    logic mw;
  } wren_t;

  typedef struct packed {
    logic fd;
    logic de;
    logic em;
  } flush_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between ID/EX and IF/ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       de_mem_read,
  input  logic [4:0] de_dst_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  // A load into r0 produces nothing the next instruction can depend on.
  assign load_use = de_mem_read && (de_dst_reg != REG_ZERO) &&
                    ((de_dst_reg == id_rs) || (id_uses_rt && (de_dst_reg == id_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-cycle stage advance enables and bubble
// injection for dmem waits, MEM redirects, mult/div, load-use and imem waits.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        em_redirect,
  input  logic        de_mem_read,
  input  logic [4:0]  de_dst_reg,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        de_muldiv,
  output logic        pc_wren,
  output logic        fd_wren,
  output logic        de_wren,
  output logic        em_wren,
  output logic        mw_wren,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic [31:0] stall_cnt
);

  localparam int CW = $clog2(MULDIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 2);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  wren_t         wr;
  flush_t        fl;
  logic          load_use;
  logic          dmem_stall;
  logic          kill;
  logic          muldiv_busy;

  hazard_detect u_hazard (
    .de_mem_read (de_mem_read),
    .de_dst_reg  (de_dst_reg),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  assign dmem_stall = dmem_req && !dmem_ready;
  assign kill       = (state == ST_KILL_FETCH);
  // A counter reading 0 in MULDIV is the release cycle: the muldiv rule is off.
  assign muldiv_busy = (state == ST_MULDIV) ? (cnt != '0) : de_muldiv;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    wr        = '1;
    fl        = '0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!reset_n) begin
      wr = '0;
    end else if (dmem_stall) begin
      wr = '0;
    end else if (em_redirect) begin
      fl        = '1;
      cnt_nxt   = '0;
      state_nxt = imem_ready ? ST_RUN : ST_KILL_FETCH;
    end else begin
      // While killing a stale fetch, IF/ID keeps taking bubbles regardless of EX-side stalls.
      if (muldiv_busy) begin
        wr.pc = 1'b0;
        wr.fd = kill;
        fl.fd = kill;
        wr.de = 1'b0;
        fl.em = 1'b1;
      end else if (load_use) begin
        wr.pc = 1'b0;
        wr.fd = kill;
        fl.fd = kill;
        fl.de = 1'b1;
      end else if (!imem_ready || kill) begin
        wr.pc = 1'b0;
        fl.fd = 1'b1;
      end

      if (muldiv_busy) begin
        if (state == ST_MULDIV) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!kill || imem_ready) begin
          state_nxt = ST_MULDIV;
          cnt_nxt   = CNT_LOAD;
        end
      end else begin
        state_nxt = (kill && !imem_ready) ? ST_KILL_FETCH : ST_RUN;
        cnt_nxt   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!wr.pc && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign pc_wren  = wr.pc;
  assign fd_wren  = wr.fd;
  assign de_wren  = wr.de;
  assign em_wren  = wr.em;
  assign mw_wren  = wr.mw;
  assign fd_flush = fl.fd;
  assign de_flush = fl.de;
  assign em_flush = fl.em;

endmodule
